// File: rtl/layer_sequencer_pkg.sv
// layer_sequencer_pkg: shared unit types, saturation limits and sequencer states.
// Imported by layer_sequencer, neuron_run and the interfaces.
`ifndef LAYER_SEQ_UNIT_DEFS
`define LAYER_SEQ_UNIT_DEFS
`define UNIT_MAX_VAL 8'hFF
`define UNIT_MIN_VAL 8'h00
`endif

package layer_sequencer_pkg;

    localparam int UNIT_W = 8;

    typedef logic [UNIT_W-1:0] unit_t;
    typedef logic signed [UNIT_W-1:0] unit_signed_t;

    localparam unit_t UNIT_MAX = `UNIT_MAX_VAL;
    localparam unit_t UNIT_MIN = `UNIT_MIN_VAL;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EVAL,
        DONE
    } layer_seq_state_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// layer_ctrl_if: controller start/done handshake; param_mem_if: parameter memory read port.
// Build option LAYER_SEQ_SAT_STATS_EN adds the saturation counters to layer_ctrl_if.
interface layer_ctrl_if #(
    parameter int N = 16,
    parameter int M = 8
);
    import layer_sequencer_pkg::*;

    logic start;
    unit_t [N-1:0] in_vec;
    logic busy;
    logic done;
    unit_t [M-1:0] out_vec;

`ifdef LAYER_SEQ_SAT_STATS_EN
    localparam int SW = $clog2(M + 1);
    logic [SW-1:0] sat_hi_count;
    logic [SW-1:0] sat_lo_count;

    modport master (
        output start, in_vec,
        input busy, done, out_vec, sat_hi_count, sat_lo_count
    );
    modport slave (
        input start, in_vec,
        output busy, done, out_vec, sat_hi_count, sat_lo_count
    );
`else
    modport master (
        output start, in_vec,
        input busy, done, out_vec
    );
    modport slave (
        input start, in_vec,
        output busy, done, out_vec
    );
`endif
endinterface

interface param_mem_if #(
    parameter int AW = 8
);
    import layer_sequencer_pkg::*;

    logic en;
    logic [AW-1:0] addr;
    unit_signed_t rdata;

    modport master (output en, addr, input rdata);
    modport slave (input en, addr, output rdata);
endinterface

// File: rtl/layer_sequencer_neuron.sv
// neuron_run: combinational neuron; floor-average of input*weight products,
// clamped to the activation bounds and offset by the lower bound when in range.
module neuron_run
    import layer_sequencer_pkg::*;
#(
    parameter int N = 16
) (
    input  unit_t [N-1:0]        inputs,
    input  unit_signed_t [N-1:0] weights,
    input  unit_signed_t         activation_upper_bound,
    input  unit_signed_t         activation_lower_bound,
    output unit_t                out,
    output logic                 average_too_big,
    output logic                 average_too_small
);
    localparam int SW = 2 * UNIT_W + 1 + $clog2(N);
    localparam int XW = SW - UNIT_W;

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] avg;
    logic signed [SW-1:0] ub;
    logic signed [SW-1:0] lb;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum
                + $signed({{XW{1'b0}}, inputs[i]})
                * $signed({{XW{weights[i][UNIT_W-1]}}, weights[i]});
        end
    end

    assign avg = sum >>> $clog2(N);
    assign ub = $signed({{XW{activation_upper_bound[UNIT_W-1]}},
                         activation_upper_bound});
    assign lb = $signed({{XW{activation_lower_bound[UNIT_W-1]}},
                         activation_lower_bound});

    assign average_too_big = avg > ub;
    assign average_too_small = avg < lb;

    always_comb begin
        out = unit_t'(avg - lb);
        if (average_too_big) begin
            out = UNIT_MAX;
        end else if (average_too_small) begin
            out = UNIT_MIN;
        end
    end
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs one neuron_run across the M neurons of a layer.
// Build option LAYER_SEQ_SAT_STATS_EN enables saturation hi/lo counters.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 8,
    parameter int AW = $clog2(M * (N + 2))
) (
    input logic         clk,
    input logic         rst,
    layer_ctrl_if.slave ctrl,
    param_mem_if.master mem
);
    localparam int KW = $clog2(N + 3);
    localparam int JW = (M > 1) ? $clog2(M) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N + 2);
    localparam logic [JW-1:0] J_LAST = JW'(M - 1);
    localparam logic [AW-1:0] STRIDE = AW'(N + 2);

    layer_seq_state_t state;
    layer_seq_state_t state_nx;

    logic [KW-1:0] k;
    logic [JW-1:0] j;
    logic [AW-1:0] base;
    unit_t [N-1:0] in_q;
    unit_signed_t [N+1:0] prm;
    unit_t [M-1:0] out_q;
    unit_t nr_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mem.en = 1'b0;
        mem.addr = '0;
        ctrl.busy = 1'b0;
        ctrl.done = 1'b0;
        unique case (state)
            IDLE: begin
                if (ctrl.start) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                ctrl.busy = 1'b1;
                if (k == K_LAST) begin
                    state_nx = EVAL;
                end else begin
                    mem.en = 1'b1;
                    mem.addr = base + AW'(k);
                end
            end
            EVAL: begin
                ctrl.busy = 1'b1;
                state_nx = (j == J_LAST) ? DONE : FETCH;
            end
            DONE: begin
                ctrl.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so word k-1 lands while k is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
            j <= '0;
            base <= '0;
            in_q <= '0;
            prm <= '0;
            out_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ctrl.start) begin
                        in_q <= ctrl.in_vec;
                        k <= '0;
                        j <= '0;
                        base <= '0;
                    end
                end
                FETCH: begin
                    for (int i = 0; i < N + 2; i++) begin
                        if (k == KW'(i + 1)) begin
                            prm[i] <= mem.rdata;
                        end
                    end
                    if (k != K_LAST) begin
                        k <= k + KW'(1);
                    end
                end
                EVAL: begin
                    for (int i = 0; i < M; i++) begin
                        if (j == JW'(i)) begin
                            out_q[i] <= nr_out;
                        end
                    end
                    if (j != J_LAST) begin
                        j <= j + JW'(1);
                        k <= '0;
                        base <= base + STRIDE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ctrl.out_vec = out_q;

`ifdef LAYER_SEQ_SAT_STATS_EN
    localparam int SW = $clog2(M + 1);

    logic too_big;
    logic too_small;
    logic [SW-1:0] hi_q;
    logic [SW-1:0] lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == IDLE && ctrl.start) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == EVAL) begin
            hi_q <= hi_q + SW'(too_big);
            lo_q <= lo_q + SW'(too_small);
        end
    end

    assign ctrl.sat_hi_count = hi_q;
    assign ctrl.sat_lo_count = lo_q;
`endif

    neuron_run #(
        .N(N)
    ) u_neuron (
        .inputs                 (in_q),
        .weights                (prm[N-1:0]),
        .activation_upper_bound (prm[N]),
        .activation_lower_bound (prm[N+1]),
        .out                    (nr_out),
`ifdef LAYER_SEQ_SAT_STATS_EN
        .average_too_big        (too_big),
        .average_too_small      (too_small)
`else
        .average_too_big        (),
        .average_too_small      ()
`endif
    );
endmodule
